// File: rtl/ucsbece154b_dmem_lat.sv
// Data-memory responder with a fixed, configurable access latency.
// One request is outstanding at a time. The request is captured on the accept
// edge. The storage access and the rvalid_o pulse happen LATENCY edges later.
module ucsbece154b_dmem_lat #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  input  logic [3:0]  be_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rd_o
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | request captured, counting down the access latency
  // RESP  | access done, rvalid_o high for this single cycle
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  logic [1:0]  state;
  logic [3:0]  count;
  logic        req_we;
  logic [29:0] req_word;
  logic [31:0] req_wd;
  logic [3:0]  req_be;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   idx;
  logic          in_range;
  logic          go_resp;
  logic [AW-1:0] widx;

  // Word index relative to BASE_ADDR. The subtraction wraps, so an address
  // below the base gives a huge index and falls out of range.
  always_comb begin
    idx      = req_word - BASE_WORD;
    in_range = ({2'b00, idx} < 32'(DEPTH_WORDS));
    widx     = idx[AW-1:0];
    go_resp  = (state == WAIT) && (count == 4'd1);
  end

  assign ready_o = (state == IDLE);

  // Request capture, latency countdown and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      rvalid_o <= 1'b0;
      rd_o     <= 32'h0;
      req_we   <= 1'b0;
      req_word <= 30'h0;
      req_wd   <= 32'h0;
      req_be   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          rvalid_o <= 1'b0;
          if (req_i) begin
            req_we   <= we_i;
            req_word <= a_i[31:2];
            req_wd   <= wd_i;
            req_be   <= be_i;
            count    <= 4'(LATENCY);
            state    <= WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (go_resp) begin
            state    <= RESP;
            rvalid_o <= 1'b1;
            rd_o     <= (!req_we && in_range) ? mem[widx] : 32'h0;
          end
        end
        RESP: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane storage write. The array is never cleared. A reset on the commit
  // edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && req_we && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) mem[widx][8*k +: 8] <= req_wd[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_dmem_lat.sv
// Directed bench for the latency data memory. One instance uses LATENCY=3 and
// the other uses LATENCY=1. Both instances share clock, reset and the request payload.
module tb_ucsbece154b_dmem_lat;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req1;
  logic        we;
  logic [31:0] addr, wd;
  logic [3:0]  be;
  logic        ready, rvalid, ready1, rvalid1;
  logic [31:0] rd, rd1;

  int checks   = 0;
  int failures = 0;

  ucsbece154b_dmem_lat #(.DEPTH_WORDS(64), .LATENCY(3), .BASE_ADDR(32'h10000000)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .a_i(addr), .wd_i(wd), .be_i(be),
    .ready_o(ready), .rvalid_o(rvalid), .rd_o(rd));

  ucsbece154b_dmem_lat #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h10000000)) dut1 (
    .clk(clk), .reset(reset), .req_i(req1), .we_i(we), .a_i(addr), .wd_i(wd), .be_i(be),
    .ready_o(ready1), .rvalid_o(rvalid1), .rd_o(rd1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance sel (0: LATENCY=3, 1: LATENCY=1). Ready and
  // rvalid are checked after every edge from the accept edge E0 through E(L+1).
  // With spam=1, req is held high while the memory is busy. These extra
  // requests must be dropped.
  task automatic xact(input int sel, input logic w, input logic [31:0] ad,
                      input logic [31:0] d, input logic [3:0] b,
                      input logic [31:0] exp_rd, input bit spam, input string tag);
    int l;
    l = (sel == 1) ? 1 : 3;
    we = w; addr = ad; wd = d; be = b;
    if (sel == 1) req1 = 1'b1; else req = 1'b1;
    chk({tag, "_ready_pre"}, {31'b0, (sel == 1) ? ready1 : ready}, 32'd1);
    tick();
    if (sel == 1) req1 = spam; else req = spam;
    for (int k = 0; k <= l + 1; k++) begin
      if (k > 0) tick();
      chk($sformatf("%s_ready_e%0d", tag, k), {31'b0, (sel == 1) ? ready1 : ready},
          (k <= l) ? 32'd0 : 32'd1);
      chk($sformatf("%s_rvalid_e%0d", tag, k), {31'b0, (sel == 1) ? rvalid1 : rvalid},
          (k == l) ? 32'd1 : 32'd0);
      if (k == l) begin
        chk({tag, "_rd"}, (sel == 1) ? rd1 : rd, exp_rd);
        req = 1'b0; req1 = 1'b0;
      end
    end
    if (sel == 1) chk({tag, "_rd_hold"}, rd1, exp_rd);
    else chk({tag, "_rd_hold"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; req1 = 1'b0; we = 1'b0;
    addr = 32'h0; wd = 32'h0; be = 4'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rd", rd, 32'h0);
    chk("rst_ready1", {31'b0, ready1}, 32'd1);
    chk("rst_rvalid1", {31'b0, rvalid1}, 32'd0);

    // full-word write, then read back
    xact(0, 1'b1, 32'h10000004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr1");
    xact(0, 1'b0, 32'h10000004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd1");
    // single byte lane 1
    xact(0, 1'b1, 32'h10000004, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, "wrb");
    xact(0, 1'b0, 32'h10000006, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, "rdb");
    // be=0 write changes nothing
    xact(0, 1'b1, 32'h10000004, 32'h12121212, 4'b0000, 32'h0, 1'b0, "wr_be0");
    xact(0, 1'b0, 32'h10000004, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, "rd_be0");
    // out of range read above the top, and write below the base
    xact(0, 1'b1, 32'h10000000, 32'h12345678, 4'hF, 32'h0, 1'b0, "wr_w0");
    xact(0, 1'b0, 32'h10000100, 32'h0, 4'h0, 32'h0, 1'b0, "rd_oor");
    xact(0, 1'b1, 32'h0FFFFFFC, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, "wr_oor");
    xact(0, 1'b0, 32'h10000000, 32'h0, 4'h0, 32'h12345678, 1'b0, "rd_w0");
    // top word in range
    xact(0, 1'b1, 32'h100000FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "wr_top");
    xact(0, 1'b0, 32'h100000FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "rd_top");

    // reset while a write to word 2 is waiting
    xact(0, 1'b1, 32'h10000008, 32'h11111111, 4'hF, 32'h0, 1'b0, "wr_w2");
    we = 1'b1; addr = 32'h10000008; wd = 32'h22222222; be = 4'hF; req = 1'b1;
    tick();
    req = 1'b0;
    chk("abort_busy", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_rvalid", {31'b0, rvalid}, 32'd0);
    chk("abort_rd", rd, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_no_rvalid%0d", i), {31'b0, rvalid}, 32'd0);
    end
    xact(0, 1'b0, 32'h10000008, 32'h0, 4'h0, 32'h11111111, 1'b0, "rd_w2");

    // extra requests while busy are dropped
    xact(0, 1'b1, 32'h1000000C, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b1, "spam_wr");
    xact(0, 1'b0, 32'h1000000C, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b1, "spam_rd");

    // LATENCY=1 instance
    xact(1, 1'b1, 32'h10000014, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "l1_wr");
    xact(1, 1'b0, 32'h10000014, 32'h0, 4'h0, 32'h0BADF00D, 1'b1, "l1_rd");
    xact(1, 1'b1, 32'h10000014, 32'h00770000, 4'b0100, 32'h0, 1'b1, "l1_wrb");
    xact(1, 1'b0, 32'h10000014, 32'h0, 4'h0, 32'h0B77F00D, 1'b0, "l1_rdb");
    chk("l1_other_idle", {31'b0, rvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
